// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, FP operand width and the series sequencer states.
package alu_pkg;
  localparam int FP_W = 32;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_FADD = 4'b0101;
  localparam logic [3:0] OP_FSUB = 4'b0110;
  localparam logic [3:0] OP_FMUL = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_NEXT,
    ST_WAIT_ALU,
    ST_FIN
  } seq_state_t;
endpackage

// File: rtl/seq_lat_counter.sv
// Loadable down-counter that flags zero; paces the wait for a fixed-latency ALU op.
module seq_lat_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fp_series_sequencer.sv
// Sums an N-term FP series through one shared external add ALU, one term per handshake.
module fp_series_sequencer
  import alu_pkg::*;
#(
  parameter int         ALU_LAT = 1,
  parameter int         CNT_W   = 4,
  parameter logic [3:0] ADD_OP  = OP_FADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             term_valid,
  input  logic [FP_W-1:0]  term_data,
  output logic             term_ready,
  output logic [FP_W-1:0]  alu_a,
  output logic [FP_W-1:0]  alu_b,
  output logic [3:0]       alu_op,
  input  logic [63:0]      alu_y,
  output logic             busy,
  output logic             done,
  output logic [FP_W-1:0]  result
);
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  seq_state_t       r_state, w_next;
  logic [FP_W-1:0]  r_acc, r_opb, r_result;
  logic [CNT_W-1:0] r_remaining;
  logic             w_ready, w_busy, w_done, w_xfer, w_lat_zero;
  logic             w_unused_hi;

  assign w_xfer      = term_valid & w_ready;
  assign w_unused_hi = ^alu_y[63:32];

  seq_lat_counter #(.W(4)) u_lat (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     ((r_state == ST_NEXT) && w_xfer),
    .i_load_val (LAT_LOAD),
    .i_dec      (r_state == ST_WAIT_ALU),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (start) w_next = (n_terms == '0) ? ST_FIN : ST_FIRST;
      ST_FIRST:    if (w_xfer) w_next = (r_remaining == CNT_W'(1)) ? ST_FIN : ST_NEXT;
      ST_NEXT:     if (w_xfer) w_next = ST_WAIT_ALU;
      ST_WAIT_ALU: if (w_lat_zero) w_next = (r_remaining == '0) ? ST_FIN : ST_NEXT;
      ST_FIN:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    unique case (r_state)
      ST_IDLE:           w_busy  = 1'b0;
      ST_FIRST, ST_NEXT: w_ready = 1'b1;
      ST_FIN:            w_done  = 1'b1;
      default:           ;
    endcase
  end

  // Operand registers only move on accepted terms or folded ALU results,
  // so the ALU sees stable inputs for the whole wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_opb       <= '0;
      r_remaining <= '0;
      r_result    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          if (n_terms == '0) r_acc       <= '0;
          else               r_remaining <= n_terms;
        end
        ST_FIRST: if (w_xfer) begin
          r_acc       <= term_data;
          r_remaining <= r_remaining - 1'b1;
        end
        ST_NEXT: if (w_xfer) begin
          r_opb       <= term_data;
          r_remaining <= r_remaining - 1'b1;
        end
        ST_WAIT_ALU: if (w_lat_zero) r_acc <= alu_y[FP_W-1:0];
        ST_FIN:      r_result <= r_acc;
        default:     ;
      endcase
    end
  end

  assign term_ready = w_ready;
  assign busy       = w_busy;
  assign done       = w_done;
  assign alu_a      = r_acc;
  assign alu_b      = r_opb;
  assign alu_op     = ADD_OP;
  assign result     = r_result;
endmodule

// File: tb/tb_fp_series_sequencer.sv
// Directed table-driven bench for fp_series_sequencer with a combinational positive-FP add ALU model.
module tb_fp_series_sequencer;
  import alu_pkg::*;

  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             term_valid;
  logic [31:0]      term_data;
  logic             term_ready;
  logic [31:0]      alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [63:0]      alu_y;
  logic             busy, done;
  logic [31:0]      result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_series_sequencer #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W), .ADD_OP(OP_FADD)) dut (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
    .term_valid(term_valid), .term_data(term_data), .term_ready(term_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .busy(busy), .done(done), .result(result)
  );

  // Positive normal operands only, truncating; enough for the directed values.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, e;
    logic [24:0] ma, mb, s;
    logic [31:0] t;
    int          sh;
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a[30:23] < b[30:23]) begin t = a; a = b; b = t; end
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]};
    sh = int'(ea) - int'(eb);
    mb = (sh >= 25) ? 25'h0 : (mb >> sh);
    s  = ma + mb;
    e  = ea;
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  // Upper half carries junk the block must ignore.
  always_comb alu_y = {32'hDEADBEEF, fadd(alu_a, alu_b)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]       n;
    logic [3:0][31:0] t;
    logic [31:0]      res;
    int               cyc;
    int               bs;    // cycle at which a stray start is pulsed while busy (0 = none)
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc = 0, idx = 0, rdy = 0, waits = 0;
    bit   got = 0;
    logic xfer;
    @(negedge clk);
    n_terms = v.n; start = 1'b1; term_valid = 1'b1; term_data = v.t[0];
    xfer = term_valid & term_ready;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (xfer) begin
        idx++;
        term_data = v.t[(idx < 4) ? idx : 3];
      end
      if (v.bs != 0 && cyc == v.bs) begin start = 1'b1; n_terms = 4'd1; end
      if (term_ready) rdy++;
      if (busy && !term_ready && !done) begin
        waits++;
        chk({tag, "_alu_b"}, alu_b, v.t[(idx > 0) ? idx - 1 : 0]);
      end
      if (done) got = 1;
      xfer = term_valid & term_ready;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(v.cyc));
    chk({tag, "_transfers"}, 32'(rdy), 32'(v.n));
    chk({tag, "_alu_waits"}, 32'(waits), 32'((v.n == 0) ? 0 : (v.n - 1) * ALU_LAT));
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, result, v.res);
    term_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{n: 4'd3, t: {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, res: 32'h40C00000, cyc: 6, bs: 0};
    vecs[1] = '{n: 4'd1, t: {32'h0, 32'h0, 32'h0, 32'h41900000}, res: 32'h41900000, cyc: 2, bs: 0};
    vecs[2] = '{n: 4'd0, t: {32'h0, 32'h0, 32'h0, 32'h3F800000}, res: 32'h00000000, cyc: 1, bs: 0};
    vecs[3] = '{n: 4'd2, t: {32'h0, 32'h0, 32'h3E800000, 32'h3F000000}, res: 32'h3F400000, cyc: 4, bs: 2};
    vecs[4] = '{n: 4'd4, t: {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, res: 32'h40800000, cyc: 8, bs: 3};

    rst = 1'b1; start = 1'b0; n_terms = '0; term_valid = 1'b0; term_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(term_ready), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'(4'b0101));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure between two 1.0 terms, then a start in the done cycle.
    @(negedge clk);
    n_terms = 4'd2; start = 1'b1; term_valid = 1'b1; term_data = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
    chk("bp_first_ready", 32'(term_ready), 32'd1);
    @(negedge clk);
    term_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", 32'(term_ready), 32'd1);
      chk("bp_hold_acc", alu_a, 32'h3F800000);
    end
    term_valid = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    term_valid = 1'b0;
    chk("bp_done_seen", 32'(done), 32'd1);
    start = 1'b1; n_terms = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_fin_ignored", 32'(busy), 32'd0);
    chk("bp_result", result, 32'h40000000);

    // Reset during WAIT_ALU, with a stray start issued while busy just before.
    @(negedge clk);
    n_terms = 4'd3; start = 1'b1; term_valid = 1'b1; term_data = 32'h3F800000;
    @(negedge clk);
    start = 1'b1; n_terms = 4'd1;
    @(negedge clk);
    start = 1'b0; term_data = 32'h40000000;
    @(negedge clk);
    chk("rstmid_in_wait", 32'({busy, term_ready}), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_result", result, 32'h0);
    term_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
